// File: rtl/pmem_ctrl.sv
// rtl/pmem_ctrl.sv - instruction RAM responder for fetch with byte-serial host loader
module pmem_ctrl #(
  parameter int PC_WIDTH   = 12,
  parameter int PMEM_WIDTH = 16,
  parameter int MEM_WORDS  = 2048
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   in_addr,
  output logic [PMEM_WIDTH-1:0] out_instr,
  input  logic                  in_load_start,
  input  logic                  in_load_valid,
  input  logic [7:0]            in_load_byte,
  input  logic                  in_load_last,
  output logic                  out_load_ready,
  output logic                  out_busy,
  output logic                  out_load_done,
  output logic                  out_load_err
);

  // Word index width seen by fetch, RAM index width, and a write pointer
  // wide enough to hold MEM_WORDS itself so it can saturate there.
  localparam int AW = PC_WIDTH - 1;
  localparam int MW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int PW = $clog2(MEM_WORDS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD_HI = 2'd1,
    S_LOAD_LO = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PMEM_WIDTH-1:0] r_mem [MEM_WORDS];
  logic [PW-1:0]         r_wr_ptr;
  logic [7:0]            r_hi_byte;

  logic [AW-1:0]         w_rd_idx;
  logic                  w_rd_in_range;
  logic                  w_wr_in_range;
  logic                  w_unused_addr_lsb;
  logic                  w_we;
  logic                  w_ptr_inc;
  logic                  w_hi_ld;
  logic [PMEM_WIDTH-1:0] w_wdata;

  // Byte address to word index; bit 0 selects a byte within the word and is
  // meaningless for 16-bit fetches.
  assign w_rd_idx          = in_addr[PC_WIDTH-1:1];
  assign w_unused_addr_lsb = in_addr[0];
  assign w_rd_in_range     = {1'b0, w_rd_idx} < (AW+1)'(MEM_WORDS);
  assign w_wr_in_range     = r_wr_ptr < PW'(MEM_WORDS);
  assign out_load_ready    = (r_state == S_LOAD_HI) || (r_state == S_LOAD_LO);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle loader strobes (write, pointer advance, high byte capture)
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_ptr_inc   = 1'b0;
    w_hi_ld     = 1'b0;
    w_wdata     = PMEM_WIDTH'({r_hi_byte, in_load_byte});
    case (r_state)
      S_IDLE: begin
        if (in_load_start) begin
          w_state_nxt = S_LOAD_HI;
        end
      end
      S_LOAD_HI: begin
        if (in_load_valid) begin
          w_hi_ld = 1'b1;
          if (in_load_last) begin
            // Odd-length image: the lone high byte is padded with 0x00.
            w_we        = 1'b1;
            w_wdata     = PMEM_WIDTH'({in_load_byte, 8'h00});
            w_state_nxt = S_FINISH;
          end else begin
            w_state_nxt = S_LOAD_LO;
          end
        end
      end
      S_LOAD_LO: begin
        if (in_load_valid) begin
          w_we        = 1'b1;
          w_ptr_inc   = 1'b1;
          w_state_nxt = in_load_last ? S_FINISH : S_LOAD_HI;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (w_we && w_wr_in_range) begin
      r_mem[r_wr_ptr[MW-1:0]] <= w_wdata;
    end
  end

  // Registered read port, write pointer, and busy/done/error status
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_instr     <= '0;
      out_busy      <= 1'b0;
      out_load_done <= 1'b0;
      out_load_err  <= 1'b0;
      r_wr_ptr      <= '0;
      r_hi_byte     <= 8'h00;
    end else begin
      out_load_done <= (r_state == S_FINISH);
      // Loader states return NOPs so a stalled or flushed fetch never sees stale words.
      if ((r_state == S_IDLE) && w_rd_in_range) begin
        out_instr <= r_mem[w_rd_idx[MW-1:0]];
      end else begin
        out_instr <= '0;
      end
      if ((r_state == S_IDLE) && in_load_start) begin
        out_busy     <= 1'b1;
        out_load_err <= 1'b0;
        r_wr_ptr     <= '0;
      end
      if (r_state == S_FINISH) begin
        out_busy <= 1'b0;
      end
      if (w_hi_ld) begin
        r_hi_byte <= in_load_byte;
      end
      // Saturate at MEM_WORDS; further bytes are still accepted so the host can finish.
      if (w_ptr_inc && w_wr_in_range) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_we && !w_wr_in_range) begin
        out_load_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pmem_ctrl.sv
// tb/tb_pmem_ctrl.sv - scoreboard bench for pmem_ctrl, full-size and 4-word instances
module tb_pmem_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] in_addr = '0;
  logic        in_load_start = 1'b0;
  logic        in_load_valid = 1'b0;
  logic [7:0]  in_load_byte = 8'h00;
  logic        in_load_last = 1'b0;

  logic [15:0] out_instr, s_instr;
  logic        out_load_ready, s_ready;
  logic        out_busy, s_busy;
  logic        out_load_done, s_done;
  logic        out_load_err, s_err;

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int done_cnt_s = 0;

  logic [15:0] sb_q[$];
  logic [15:0] sbs_q[$];
  logic [7:0]  pat[$];

  pmem_ctrl #(.PC_WIDTH(12), .PMEM_WIDTH(16), .MEM_WORDS(2048)) dut (
    .clock(clock), .reset(reset), .in_addr(in_addr), .out_instr(out_instr),
    .in_load_start(in_load_start), .in_load_valid(in_load_valid),
    .in_load_byte(in_load_byte), .in_load_last(in_load_last),
    .out_load_ready(out_load_ready), .out_busy(out_busy),
    .out_load_done(out_load_done), .out_load_err(out_load_err)
  );

  pmem_ctrl #(.PC_WIDTH(12), .PMEM_WIDTH(16), .MEM_WORDS(4)) dut_small (
    .clock(clock), .reset(reset), .in_addr(in_addr), .out_instr(s_instr),
    .in_load_start(in_load_start), .in_load_valid(in_load_valid),
    .in_load_byte(in_load_byte), .in_load_last(in_load_last),
    .out_load_ready(s_ready), .out_busy(s_busy),
    .out_load_done(s_done), .out_load_err(s_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (out_load_done === 1'b1) done_cnt++;
    if (s_done === 1'b1) done_cnt_s++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  task automatic start_load();
    in_load_start = 1'b1;
    @(posedge clock); #1;
    in_load_start = 1'b0;
  endtask

  task automatic load_pat(input int max_gap, input bit stray, input bit mark_last, output bit ok);
    bit got;
    int gap;
    ok = 1'b1;
    foreach (pat[i]) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        in_load_valid = 1'b0;
        in_load_start = stray && ($urandom_range(1, 0) == 1);
        @(posedge clock); #1;
      end
      in_load_start = 1'b0;
      in_load_valid = 1'b1;
      in_load_byte  = pat[i];
      in_load_last  = mark_last && (i == pat.size() - 1);
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        got = out_load_ready && s_ready;
        @(posedge clock); #1;
      end
      in_load_valid = 1'b0;
      in_load_last  = 1'b0;
      if (!got) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (out_instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h want 0000", out_instr); end
    n_tests++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", out_busy); end
    n_tests++; if (out_load_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", out_load_done); end
    n_tests++; if (out_load_err !== 1'b0 || s_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b/%b want 0/0", out_load_err, s_err); end
    n_tests++; if (out_load_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", out_load_ready); end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [11:0] a[3];
    logic [15:0] e[3];
    logic [15:0] x;
    bit ok;
    int d0;
    a = '{12'h000, 12'h002, 12'h004};
    e = '{16'h1234, 16'hABCD, 16'h0001};
    in_addr = 12'h000;
    d0 = done_cnt;
    start_load();
    n_tests++; if (out_busy !== 1'b1 || out_load_ready !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start got %b/%b want 1/1", out_busy, out_load_ready); end
    pat = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    load_pat(0, 1'b0, 1'b1, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_handshake got stalled want accepted"); end
    n_tests++; if (out_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_last got %b want 1", out_busy); end
    n_tests++; if (out_instr !== 16'h0000) begin n_fail++; $display("FAIL basic_nop got %h want 0000", out_instr); end
    @(posedge clock); #1;
    n_tests++; if (out_load_done !== 1'b1 || out_busy !== 1'b0) begin n_fail++; $display("FAIL basic_done got done=%b busy=%b want 1/0", out_load_done, out_busy); end
    for (int i = 0; i < 3; i++) begin
      in_addr = a[i];
      sb_q.push_back(e[i]);
      @(posedge clock); #1;
      x = sb_q.pop_front();
      n_tests++; if (out_instr !== x) begin n_fail++; $display("FAIL basic_read[%0d] got %h want %h", i, out_instr, x); end
    end
    n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); end
    n_tests++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL basic_small_err got %b want 0", s_err); end
  endtask

  task automatic test_odd_length();
    logic [11:0] a[3];
    logic [15:0] e[3];
    logic [15:0] x;
    bit ok;
    a = '{12'h003, 12'h000, 12'h004};
    e = '{16'h9A00, 16'h7E55, 16'h0001};
    in_addr = 12'h002;
    start_load();
    n_tests++; if (out_instr !== 16'hABCD || out_busy !== 1'b1) begin n_fail++; $display("FAIL odd_read_with_start got %h busy=%b want abcd busy=1", out_instr, out_busy); end
    pat = '{8'h7E, 8'h55, 8'h9A};
    load_pat(0, 1'b0, 1'b1, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL odd_handshake got stalled want accepted"); end
    @(posedge clock); #1;
    n_tests++; if (out_load_done !== 1'b1) begin n_fail++; $display("FAIL odd_done got %b want 1", out_load_done); end
    for (int i = 0; i < 3; i++) begin
      in_addr = a[i];
      sb_q.push_back(e[i]);
      @(posedge clock); #1;
      x = sb_q.pop_front();
      n_tests++; if (out_instr !== x) begin n_fail++; $display("FAIL odd_read[%0d] got %h want %h", i, out_instr, x); end
    end
  endtask

  task automatic test_async_reset();
    in_addr = 12'h000;
    @(posedge clock); #1;
    n_tests++; if (out_instr !== 16'h7E55) begin n_fail++; $display("FAIL areset_pre got %h want 7e55", out_instr); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (out_instr !== 16'h0000 || s_instr !== 16'h0000 || out_busy !== 1'b0) begin n_fail++; $display("FAIL areset_immediate got %h/%h busy=%b want 0000/0000 busy=0", out_instr, s_instr, out_busy); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_gaps_and_strays();
    logic [11:0] a[3];
    logic [15:0] e[3];
    logic [15:0] x;
    bit ok;
    int d0;
    a = '{12'h000, 12'h002, 12'h004};
    e = '{16'h1234, 16'hABCD, 16'h0001};
    d0 = done_cnt;
    in_load_valid = 1'b1; in_load_byte = 8'hFF; in_load_last = 1'b1;
    repeat (4) begin @(posedge clock); #1; end
    in_load_valid = 1'b0; in_load_last = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    n_tests++; if (out_busy !== 1'b0 || out_load_ready !== 1'b0 || out_load_err !== 1'b0) begin n_fail++; $display("FAIL stray_idle got busy=%b ready=%b err=%b want 0/0/0", out_busy, out_load_ready, out_load_err); end
    n_tests++; if (done_cnt !== d0) begin n_fail++; $display("FAIL stray_idle_done got %0d want %0d", done_cnt, d0); end
    start_load();
    pat = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    load_pat(3, 1'b1, 1'b1, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL gaps_handshake got stalled want accepted"); end
    @(posedge clock); #1;
    n_tests++; if (out_load_done !== 1'b1) begin n_fail++; $display("FAIL gaps_done got %b want 1", out_load_done); end
    for (int i = 0; i < 3; i++) begin
      in_addr = a[i];
      sb_q.push_back(e[i]);
      @(posedge clock); #1;
      x = sb_q.pop_front();
      n_tests++; if (out_instr !== x) begin n_fail++; $display("FAIL gaps_read[%0d] got %h want %h", i, out_instr, x); end
    end
    n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL gaps_done_count got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_overflow();
    logic [11:0] a[5];
    logic [15:0] eb[5];
    logic [15:0] es[5];
    logic [15:0] x, y;
    bit ok;
    int d0;
    a  = '{12'h000, 12'h002, 12'h004, 12'h006, 12'h008};
    eb = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A};
    es = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h0000};
    d0 = done_cnt_s;
    start_load();
    pat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    load_pat(0, 1'b0, 1'b1, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ovf_handshake got stalled want accepted"); end
    @(posedge clock); #1;
    n_tests++; if (s_done !== 1'b1 || out_load_done !== 1'b1) begin n_fail++; $display("FAIL ovf_done got %b/%b want 1/1", s_done, out_load_done); end
    n_tests++; if (s_err !== 1'b1 || out_load_err !== 1'b0) begin n_fail++; $display("FAIL ovf_err got small=%b big=%b want 1/0", s_err, out_load_err); end
    for (int i = 0; i < 5; i++) begin
      in_addr = a[i];
      sb_q.push_back(eb[i]);
      sbs_q.push_back(es[i]);
      @(posedge clock); #1;
      x = sb_q.pop_front();
      y = sbs_q.pop_front();
      n_tests++; if (s_instr !== y) begin n_fail++; $display("FAIL ovf_small_read[%0d] got %h want %h", i, s_instr, y); end
      n_tests++; if (out_instr !== x) begin n_fail++; $display("FAIL ovf_big_read[%0d] got %h want %h", i, out_instr, x); end
    end
    n_tests++; if (done_cnt_s - d0 !== 1) begin n_fail++; $display("FAIL ovf_done_count got %0d want 1", done_cnt_s - d0); end
  endtask

  task automatic test_mid_reset();
    logic [11:0] a[2];
    logic [15:0] e[2];
    logic [15:0] x, y;
    bit ok;
    int d0;
    a = '{12'h000, 12'h002};
    e = '{16'h5AA5, 16'h0304};
    start_load();
    n_tests++; if (s_err !== 1'b0 || out_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_start got err=%b busy=%b want 0/1", s_err, out_busy); end
    pat = '{8'h5A, 8'hA5, 8'hC3};
    load_pat(0, 1'b0, 1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL midrst_handshake got stalled want accepted"); end
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    n_tests++; if (out_busy !== 1'b0 || out_load_ready !== 1'b0 || s_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_immediate got busy=%b ready=%b sbusy=%b want 0/0/0", out_busy, out_load_ready, s_busy); end
    reset = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    n_tests++; if (done_cnt !== d0 || out_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done got done_delta=%0d busy=%b want 0/0", done_cnt - d0, out_busy); end
    for (int i = 0; i < 2; i++) begin
      in_addr = a[i];
      sb_q.push_back(e[i]);
      sbs_q.push_back(e[i]);
      @(posedge clock); #1;
      x = sb_q.pop_front();
      y = sbs_q.pop_front();
      n_tests++; if (out_instr !== x || s_instr !== y) begin n_fail++; $display("FAIL midrst_read[%0d] got %h/%h want %h/%h", i, out_instr, s_instr, x, y); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_length();
    test_async_reset();
    test_gaps_and_strays();
    test_overflow();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pmem_ctrl.md
Name: pmem_ctrl

Overview:
Program-memory responder for the fetch stage. It owns a single-port instruction RAM and answers fetch's byte address with a 16-bit instruction one cycle later (synchronous read), which pairs that word with fetch's registered PC. It also contains a byte-serial loader FSM that fills the RAM from an external host. While loading, it holds fetch stalled through out_busy and returns NOPs (0x0000).

Parameters:
PC_WIDTH, 12, width of the byte address from fetch.
PMEM_WIDTH, 16, instruction word width; fixed at 2 bytes per word.
MEM_WORDS, 2048, RAM depth in words; must be ≤ 2^(PC_WIDTH-1).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_addr  in  PC_WIDTH  byte address from fetch (its pmem address output). Word index is in_addr[PC_WIDTH-1:1]; bit 0 is ignored.
out_instr  out  PMEM_WIDTH  registered read data, returned to fetch's instruction input.
in_load_start  in  1  one-cycle pulse that begins a load session; honoured only in S_IDLE.
in_load_valid  in  1  in_load_byte is valid this cycle.
in_load_byte  in  8  load data byte; high byte of each word is sent first.
in_load_last  in  1  qualifies the final byte of the session; meaningful only with in_load_valid.
out_load_ready  out  1  high in S_LOAD_HI and S_LOAD_LO; a byte transfers when valid && ready.
out_busy  out  1  stall request to fetch; registered.
out_load_done  out  1  one-cycle pulse when a session completes.
out_load_err  out  1  sticky overflow flag; cleared by the next accepted in_load_start or by reset.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=S_IDLE; out_instr=0; out_busy=0; out_load_done=0; out_load_err=0.
  - Write pointer wr_ptr=0; hi_byte register=0.
  - RAM contents are not reset.
- States:
  - S_IDLE
  - S_LOAD_HI: waiting for the high byte.
  - S_LOAD_LO: waiting for the low byte.
  - S_FINISH: single cycle.
- S_IDLE:
  - Every cycle: out_instr <= mem[in_addr[PC_WIDTH-1:1]]. Read latency is exactly 1 cycle.
  - If the word index ≥ MEM_WORDS, out_instr <= 0.
  - On in_load_start: go to S_LOAD_HI; wr_ptr<=0; out_busy<=1; out_load_err<=0.
- S_LOAD_HI, on a transfer:
  - hi_byte <= in_load_byte.
  - If in_load_last: write {byte,8'h00} to mem[wr_ptr] (odd length is padded with 0x00), then go to S_FINISH.
  - Otherwise go to S_LOAD_LO.
- S_LOAD_LO, on a transfer:
  - Write {hi_byte,byte} to mem[wr_ptr]; wr_ptr <= wr_ptr+1.
  - Go to S_FINISH if in_load_last, else S_LOAD_HI.
- Overflow:
  - A write with wr_ptr ≥ MEM_WORDS is suppressed and sets out_load_err=1.
  - wr_ptr saturates at MEM_WORDS and does not wrap.
  - Byte acceptance continues until in_load_last, so the host is never deadlocked.
- S_FINISH:
  - out_load_done <= 1 for one cycle; out_busy <= 0; go to S_IDLE.
  - The first real read occurs in the S_IDLE cycle that follows.
- During any load state: out_instr <= 0 (NOP), so flushed or stalled fetch sees no stale words.
- in_load_start while loading is ignored. in_load_valid in S_IDLE or S_FINISH is ignored (no write, no error).
- Reset mid-load:
  - Session is aborted: state S_IDLE, out_busy=0, no done pulse.
  - Words already written stay in RAM; the partial hi_byte is discarded.
- Simultaneous in_load_start and in_addr change in S_IDLE: the read for that cycle still completes; out_busy rises next edge.
- out_busy timing: rises 1 cycle after the accepted start and falls on the S_FINISH edge. Fetch drives its stall input from it directly.

Test Plan:
- Reset values: assert reset mid-cycle -> out_instr=0, out_busy=0, out_load_err=0 immediately, without waiting for a clock edge.
- Basic load/read:
  - Stimulus: start, then bytes 12 34 AB CD 00 01 with last on the 6th byte, then in_addr=0,2,4 on consecutive cycles.
  - Required: out_load_done pulses once; out_instr = 0x1234, 0xABCD, 0x0001, each one cycle after its address; out_busy high from the cycle after start through the final-byte cycle.
- Odd length: bytes 7E 55 9A with last on 9A -> mem[0]=0x7E55, mem[1]=0x9A00; in_addr=3 reads 0x9A00 (bit 0 ignored).
- Overflow: MEM_WORDS=4, load 10 bytes -> words 0..3 written, out_load_err=1, done still pulses, reads of 0/2/4/6 return the first four words.
- Gaps and stray inputs:
  - Stimulus: in_load_valid deasserted for random gaps; valid pulses in S_IDLE; start pulses during a load.
  - Required: no extra writes, no state change, data identical to the gap-free run.
- Reset at byte 3 of 6 -> state idle, out_busy=0, no done pulse; mem[0] holds the new word; mem[1] unchanged from its prior value.
